// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch front end driving a 1-cycle ROM, buffering words in a DEPTH-entry FIFO with ID backpressure and redirect flush
module if_fetch_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        rom_addr_o,
    output logic                     rom_ce_o,
    input  logic [INST_W-1:0]        rom_data_i,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [ADDR_W-1:0]        id_pc_o,
    output logic [INST_W-1:0]        id_inst_o,
    output logic [$clog2(DEPTH):0]   fq_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_W / 8);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_pc_q [DEPTH];
    logic [INST_W-1:0] r_inst_q [DEPTH];
    logic [CW-1:0]     w_used;
    logic              w_push;
    logic              w_pop;

    // Credit counts the outstanding ROM read so a returning word always has a slot
    assign w_used = r_count + CW'(r_inflight);
    assign rom_ce_o = rst & ~redirect_i & (w_used < CW'(DEPTH));
    assign rom_addr_o = r_fetch_pc;
    assign w_push = r_inflight & ~redirect_i;
    assign w_pop = id_valid_o & id_ready_i & ~redirect_i;
    assign id_valid_o = r_count != '0;
    assign id_pc_o = id_valid_o ? r_pc_q[r_rd_ptr] : '0;
    assign id_inst_o = id_valid_o ? r_inst_q[r_rd_ptr] : '0;
    assign fq_count_o = r_count;

    // Fetch PC, in-flight tracking and queue pointers; redirect flushes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count <= '0;
        end else if (redirect_i) begin
            r_fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
            r_inflight <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count <= '0;
        end else begin
            r_inflight <= rom_ce_o;
            if (rom_ce_o) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + INC;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage; contents are only visible while the entry is counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_wr_ptr] <= r_inflight_pc;
            r_inst_q[r_wr_ptr] <= rom_data_i;
        end
    end
endmodule
